// File: rtl/rf_pkg.sv
// Shared register-file constants: default geometry and the hardwired-zero register index.
package rf_pkg;
   localparam int RF_DATA_W   = 8;
   localparam int RF_ADDR_W   = 3;
   localparam int RF_ZERO_IDX = 0;
endpackage

// File: rtl/rf_scoreboard.sv
// Pending-bit scoreboard: one bit per register, set by reservations, cleared by committed writes.
module rf_scoreboard
   import rf_pkg::*;
#(
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int ZERO_REG = 1
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              res_en_i,
   input  logic [ADDR_W-1:0] res_addr_i,
   input  logic              clr0_i,
   input  logic [ADDR_W-1:0] clr0_addr_i,
   input  logic              clr1_i,
   input  logic [ADDR_W-1:0] clr1_addr_i,
   input  logic [ADDR_W-1:0] rx_i,
   input  logic [ADDR_W-1:0] ry_i,
   input  logic              hit_x_i,
   input  logic              hit_y_i,
   output logic              ready_x_o,
   output logic              ready_y_o,
   output logic              conflict_o
);
   localparam int NUM_REG = 1 << ADDR_W;

   logic [NUM_REG-1:0] pend_q, pend_d;
   logic               res_ok;

   assign res_ok = res_en_i &&
                   !((ZERO_REG != 0) && (res_addr_i == ADDR_W'(RF_ZERO_IDX)));

   // Set is applied last so a new producer supersedes a retiring one.
   always_comb begin
      pend_d = pend_q;
      if (clr0_i) pend_d[clr0_addr_i] = 1'b0;
      if (clr1_i) pend_d[clr1_addr_i] = 1'b0;
      if (res_ok) pend_d[res_addr_i]  = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) pend_q <= '0;
      else       pend_q <= pend_d;
   end

   assign ready_x_o  = !pend_q[rx_i] || hit_x_i;
   assign ready_y_o  = !pend_q[ry_i] || hit_y_i;
   assign conflict_o = res_ok && pend_q[res_addr_i];
endmodule

// File: rtl/register_file_sb.sv
// Two-write, two-read register file with fixed write priority, optional bypass and a scoreboard.
module register_file_sb
   import rf_pkg::*;
#(
   parameter int DATA_W   = RF_DATA_W,
   parameter int ADDR_W   = RF_ADDR_W,
   parameter int BYPASS   = 1,
   parameter int ZERO_REG = 1
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              WEN0,
   input  logic [ADDR_W-1:0] RW0,
   input  logic [DATA_W-1:0] busW0,
   input  logic              WEN1,
   input  logic [ADDR_W-1:0] RW1,
   input  logic [DATA_W-1:0] busW1,
   input  logic [ADDR_W-1:0] RX,
   input  logic [ADDR_W-1:0] RY,
   output logic [DATA_W-1:0] busX,
   output logic [DATA_W-1:0] busY,
   input  logic              RES_EN,
   input  logic [ADDR_W-1:0] RD_RES,
   output logic              readyX,
   output logic              readyY,
   output logic              res_conflict
);
   localparam int NUM_REG = 1 << ADDR_W;
   localparam logic [ADDR_W-1:0] ZIDX = ADDR_W'(RF_ZERO_IDX);

   logic [NUM_REG-1:0][DATA_W-1:0] regs_q, regs_d;
   logic wc0, wc1, hit0_x, hit1_x, hit0_y, hit1_y, hit_x, hit_y, zx, zy;

   // A write to the hardwired-zero register never commits, so it neither stores nor bypasses.
   assign wc0 = WEN0 && !((ZERO_REG != 0) && (RW0 == ZIDX));
   assign wc1 = WEN1 && !((ZERO_REG != 0) && (RW1 == ZIDX));

   always_comb begin
      regs_d = regs_q;
      if (wc0) regs_d[RW0] = busW0;
      if (wc1) regs_d[RW1] = busW1;
   end

   always_ff @(posedge Clk) begin
      if (Rst) regs_q <= '0;
      else     regs_q <= regs_d;
   end

   assign hit1_x = (BYPASS != 0) && wc1 && (RW1 == RX);
   assign hit0_x = (BYPASS != 0) && wc0 && (RW0 == RX);
   assign hit1_y = (BYPASS != 0) && wc1 && (RW1 == RY);
   assign hit0_y = (BYPASS != 0) && wc0 && (RW0 == RY);
   assign hit_x  = hit1_x || hit0_x;
   assign hit_y  = hit1_y || hit0_y;
   assign zx     = (ZERO_REG != 0) && (RX == ZIDX);
   assign zy     = (ZERO_REG != 0) && (RY == ZIDX);

   always_comb begin
      busX = regs_q[RX];
      if (zx)          busX = '0;
      else if (hit1_x) busX = busW1;
      else if (hit0_x) busX = busW0;
   end

   always_comb begin
      busY = regs_q[RY];
      if (zy)          busY = '0;
      else if (hit1_y) busY = busW1;
      else if (hit0_y) busY = busW0;
   end

   rf_scoreboard #(
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
   ) u_sb (
      .clk_i       (Clk),
      .rst_i       (Rst),
      .res_en_i    (RES_EN),
      .res_addr_i  (RD_RES),
      .clr0_i      (wc0),
      .clr0_addr_i (RW0),
      .clr1_i      (wc1),
      .clr1_addr_i (RW1),
      .rx_i        (RX),
      .ry_i        (RY),
      .hit_x_i     (hit_x),
      .hit_y_i     (hit_y),
      .ready_x_o   (readyX),
      .ready_y_o   (readyY),
      .conflict_o  (res_conflict)
   );
endmodule

// File: tb/tb_register_file_sb.sv
// Randomized bench for register_file_sb against an array-based model, plus directed literal checks.
module tb_register_file_sb;
   logic       Clk = 1'b0;
   logic       Rst, WEN0, WEN1, RES_EN;
   logic [2:0] RW0, RW1, RX, RY, RD_RES;
   logic [7:0] busW0, busW1, busX, busY;
   logic       readyX, readyY, res_conflict;

   logic [7:0] mreg [8];
   bit         mpend[8];
   bit         chk_en = 1'b0;
   int         tests = 0, fails = 0;

   always #5 Clk = ~Clk;

   register_file_sb #(.DATA_W(8), .ADDR_W(3), .BYPASS(1), .ZERO_REG(1)) dut (
      .Clk(Clk), .Rst(Rst),
      .WEN0(WEN0), .RW0(RW0), .busW0(busW0),
      .WEN1(WEN1), .RW1(RW1), .busW1(busW1),
      .RX(RX), .RY(RY), .busX(busX), .busY(busY),
      .RES_EN(RES_EN), .RD_RES(RD_RES),
      .readyX(readyX), .readyY(readyY), .res_conflict(res_conflict)
   );

   // Model view: the value a reader must see this cycle, newest writer first.
   function automatic logic [7:0] exp_bus(input logic [2:0] a);
      if (a == 3'd0) return 8'h00;
      if (WEN1 && RW1 == a) return busW1;
      if (WEN0 && RW0 == a) return busW0;
      return mreg[a];
   endfunction

   function automatic logic exp_rdy(input logic [2:0] a);
      if (a == 3'd0) return 1'b1;
      if ((WEN1 && RW1 == a) || (WEN0 && RW0 == a)) return 1'b1;
      return !mpend[a];
   endfunction

   function automatic logic exp_conf();
      return RES_EN && RD_RES != 3'd0 && mpend[RD_RES];
   endfunction

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(negedge Clk) begin
      if (chk_en) begin
         chk("busX",     busX,                 exp_bus(RX));
         chk("busY",     busY,                 exp_bus(RY));
         chk("readyX",   {7'd0, readyX},       {7'd0, exp_rdy(RX)});
         chk("readyY",   {7'd0, readyY},       {7'd0, exp_rdy(RY)});
         chk("conflict", {7'd0, res_conflict}, {7'd0, exp_conf()});
      end
   end

   // Commit one clock edge into the model using the inputs held across it.
   task automatic tick();
      @(posedge Clk);
      if (Rst) begin
         for (int i = 0; i < 8; i++) begin mreg[i] = 8'h00; mpend[i] = 1'b0; end
      end else begin
         if (WEN0 && RW0 != 3'd0) begin mreg[RW0] = busW0; mpend[RW0] = 1'b0; end
         if (WEN1 && RW1 != 3'd0) begin mreg[RW1] = busW1; mpend[RW1] = 1'b0; end
         if (RES_EN && RD_RES != 3'd0) mpend[RD_RES] = 1'b1;
      end
      #1;
   endtask

   task automatic idle();
      Rst = 0; WEN0 = 0; WEN1 = 0; RES_EN = 0;
      RW0 = 0; RW1 = 0; busW0 = 0; busW1 = 0; RX = 0; RY = 0; RD_RES = 0;
   endtask

   task automatic at_neg();
      @(negedge Clk); #1;
   endtask

   initial begin
      idle();
      for (int i = 0; i < 8; i++) begin mreg[i] = 8'h00; mpend[i] = 1'b0; end
      Rst = 1; tick(); tick();
      // Arbitrary writes and reservations, then reset held two cycles.
      Rst = 0; chk_en = 1;
      for (int i = 0; i < 6; i++) begin
         WEN0 = 1; RW0 = 3'(i + 1); busW0 = 8'($urandom);
         WEN1 = 1; RW1 = 3'(7 - i); busW1 = 8'($urandom);
         RES_EN = 1; RD_RES = 3'(i + 2);
         tick();
      end
      idle(); Rst = 1; tick(); tick();
      idle();
      for (int a = 0; a < 8; a++) begin
         RX = 3'(a); RY = 3'(7 - a);
         at_neg();
         chk("rst_busX", busX, 8'h00);
         chk("rst_busY", busY, 8'h00);
         chk("rst_rdy",  {6'd0, readyX, readyY}, 8'h03);
         tick();
      end

      // reg3 via port 0, then reg0 write discarded.
      WEN0 = 1; RW0 = 3; busW0 = 8'hA5; tick();
      idle(); RX = 3; RY = 0; at_neg();
      chk("r3_busX", busX, 8'hA5);
      chk("r3_busY", busY, 8'h00);
      tick();
      WEN0 = 1; RW0 = 0; busW0 = 8'hFF; RY = 0; at_neg();
      chk("r0_wr_same", busY, 8'h00);
      tick(); idle(); at_neg();
      chk("r0_wr_next", busY, 8'h00);
      tick();

      // Same-address dual write: port 1 wins, both stored and bypassed.
      WEN0 = 1; RW0 = 5; busW0 = 8'h11; WEN1 = 1; RW1 = 5; busW1 = 8'h22; RX = 5;
      at_neg(); chk("dual_byp", busX, 8'h22);
      tick(); idle(); RX = 5; at_neg();
      chk("dual_store", busX, 8'h22);
      tick();

      // Reservation then retiring write with bypass.
      RES_EN = 1; RD_RES = 6; tick();
      idle(); RX = 6; at_neg();
      chk("res6_rdy", {7'd0, readyX}, 8'h00);
      tick();
      WEN0 = 1; RW0 = 6; busW0 = 8'h3C; RX = 6; at_neg();
      chk("wr6_byp_rdy", {7'd0, readyX}, 8'h01);
      tick(); idle(); RX = 6; at_neg();
      chk("wr6_rdy", {7'd0, readyX}, 8'h01);
      chk("wr6_bus", busX, 8'h3C);
      tick();

      // WAW conflict, then set beating clear.
      RES_EN = 1; RD_RES = 2; at_neg();
      chk("res2_first", {7'd0, res_conflict}, 8'h00);
      tick(); at_neg();
      chk("res2_second", {7'd0, res_conflict}, 8'h01);
      tick();
      WEN1 = 1; RW1 = 2; busW1 = 8'h77; tick();
      idle(); RX = 2; at_neg();
      chk("setclr_rdy", {7'd0, readyX}, 8'h00);
      chk("setclr_bus", busX, 8'h77);
      tick();

      // Reset overrides a same-cycle write and reservation.
      Rst = 1; WEN1 = 1; RW1 = 4; busW1 = 8'h99; RES_EN = 1; RD_RES = 4; tick();
      idle(); RX = 4; at_neg();
      chk("rst_ovr_bus", busX, 8'h00);
      chk("rst_ovr_rdy", {7'd0, readyX}, 8'h01);
      tick();

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         Rst    = ($urandom_range(0, 99) < 2);
         WEN0   = $urandom_range(0, 1);  RW0 = 3'($urandom); busW0 = 8'($urandom);
         WEN1   = $urandom_range(0, 1);  RW1 = 3'($urandom); busW1 = 8'($urandom);
         RES_EN = ($urandom_range(0, 9) < 4); RD_RES = 3'($urandom);
         RX     = 3'($urandom); RY = 3'($urandom);
         tick();
      end
      idle(); tick();
      chk_en = 0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
